// File: rtl/forward_ctrl.sv
// Operand-forwarding select generator and load-use hazard detector for the 5-stage pipeline.
// Optional feature macro: LOAD_USE_STALL_EN enables load-use stall detection and the stall counter.
module forward_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } ex_stage_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } wr_stage_t;

    ex_stage_t ex_q,  ex_d;
    wr_stage_t mem_q, mem_d;
    wr_stage_t wb_q,  wb_d;
    logic      stall_c;

    // MEM result is newer than WB, so it wins; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              ex_v,
        input wr_stage_t         mem,
        input wr_stage_t         wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_v && mem.v && mem.regwrite && (mem.rd != '0) && (mem.rd == src)) begin
            sel = 2'b10;
        end else if (wb.v && wb.regwrite && (wb.rd != '0) && (wb.rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel_o = fwd_sel(ex_q.rs, ex_q.v, mem_q, wb_q);
        fwd_b_sel_o = fwd_sel(ex_q.rt, ex_q.v, mem_q, wb_q);
    end

`ifdef LOAD_USE_STALL_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // rt is compared even for instructions that do not read it; false stalls are harmless.
    always_comb begin
        stall_c = id_valid_i & ex_q.v & ex_q.memread & (ex_q.rd != '0)
                & ((ex_q.rd == id_rs_i) | (ex_q.rd == id_rt_i));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;
`else
    logic unused_memread;

    always_comb begin
        stall_c = 1'b0;
    end

    assign unused_memread = ex_q.memread;
    assign stall_cnt_o    = '0;
`endif

    assign stall_o = stall_c;

    // Pipeline shadow shift; a stalled or invalid ID slot enters EX as an all-zero bubble.
    always_comb begin
        ex_d = '0;
        if (id_valid_i && !stall_c) begin
            ex_d.v        = 1'b1;
            ex_d.rs       = id_rs_i;
            ex_d.rt       = id_rt_i;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end
        mem_d.v        = ex_q.v;
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
        wb_d           = mem_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

endmodule

// File: tb/tb_forward_ctrl.sv
// Randomized and directed bench for forward_ctrl against an instruction-level pipeline model.
module tb_forward_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              id_valid_i = 1'b0;
    logic [REG_AW-1:0] id_rs_i = '0;
    logic [REG_AW-1:0] id_rt_i = '0;
    logic [REG_AW-1:0] id_rd_i = '0;
    logic              id_regwrite_i = 1'b0;
    logic              id_memread_i = 1'b0;
    logic [1:0]        fwd_a_sel_o;
    logic [1:0]        fwd_b_sel_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_rd_i      (id_rd_i),
        .id_regwrite_i(id_regwrite_i),
        .id_memread_i (id_memread_i),
        .fwd_a_sel_o  (fwd_a_sel_o),
        .fwd_b_sel_o  (fwd_b_sel_o),
        .stall_o      (stall_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit      v;
        int      rs;
        int      rt;
        int      rd;
        bit      rw;
        bit      mr;
    } instr_t;

    // Index 0 = EX, 1 = MEM, 2 = WB.
    instr_t pipe [3];
    int     exp_cnt;
    bit     last_stall;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic instr_t bubble();
        instr_t b;
        b.v = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.rw = 0; b.mr = 0;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        exp_cnt = 0;
    endtask

    // Newest older producer of src wins: MEM gives 2, WB gives 1, none gives 0.
    function automatic int exp_sel(input int src);
        for (int k = 1; k <= 2; k++) begin
            if ((k == 2 || pipe[0].v) && pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == src)
                return (k == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic bit exp_stall(input instr_t id);
`ifdef LOAD_USE_STALL_EN
        return id.v && pipe[0].v && pipe[0].mr && pipe[0].rd != 0
            && (pipe[0].rd == id.rs || pipe[0].rd == id.rt);
`else
        return 1'b0 && id.v;
`endif
    endfunction

    // Present one ID instruction, check the combinational view, then clock and advance the model.
    task automatic step(input bit v, input int rs, input int rt, input int rd, input bit rw, input bit mr);
        instr_t id;
        bit     st;
        id.v = v; id.rs = rs; id.rt = rt; id.rd = rd; id.rw = rw; id.mr = mr;
        id_valid_i    = v;
        id_rs_i       = REG_AW'(rs);
        id_rt_i       = REG_AW'(rt);
        id_rd_i       = REG_AW'(rd);
        id_regwrite_i = rw;
        id_memread_i  = mr;
        #1;
        st = exp_stall(id);
        check("fwd_a", int'(fwd_a_sel_o), exp_sel(pipe[0].rs));
        check("fwd_b", int'(fwd_b_sel_o), exp_sel(pipe[0].rt));
        check("stall", int'(stall_o), int'(st));
        check("stall_cnt", int'(stall_cnt_o), exp_cnt);
        @(posedge clk_i);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (v && !st) ? id : bubble();
        if (st && exp_cnt != 65535) exp_cnt++;
        last_stall = st;
        #1;
    endtask

    initial begin
        int rs, rt, rd;
        bit v, rw, mr;
        model_reset();
        #12;
        check("reset_a", int'(fwd_a_sel_o), 0);
        check("reset_b", int'(fwd_b_sel_o), 0);
        check("reset_stall", int'(stall_o), 0);
        check("reset_cnt", int'(stall_cnt_o), 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // ALU chain: add $2<-$1,$1 ; sub $3<-$2,$2 -> a=10,b=10 while sub in EX
        step(1, 1, 1, 2, 1, 0);
        step(1, 2, 2, 3, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        check("alu_chain_a_const", int'(pipe[1].rd), 3);
        // Distance-2: add $4 ; unrelated ; or rt=$4 -> a=00,b=01
        step(1, 1, 1, 4, 1, 0);
        step(1, 7, 7, 8, 1, 0);
        step(1, 9, 4, 10, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        // Priority: two writes of $5 then read $5 -> a=10
        step(1, 1, 1, 5, 1, 0);
        step(1, 2, 2, 5, 1, 0);
        step(1, 5, 0, 11, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        // Load-use: lw $6 ; add rs=$6 (held in ID while stalled)
        step(1, 1, 0, 6, 1, 1);
        step(1, 6, 3, 12, 1, 0);
        if (last_stall) step(1, 6, 3, 12, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // $zero gating and invalid ID
        step(1, 1, 1, 0, 1, 0);
        step(1, 0, 0, 13, 1, 0);
        step(1, 1, 1, 0, 1, 1);
        step(1, 0, 0, 14, 1, 0);
        step(1, 1, 1, 15, 1, 1);
        step(0, 15, 15, 16, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic over a small register set so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                v  = ($urandom_range(0, 9) != 0);
                rs = $urandom_range(0, 7);
                rt = $urandom_range(0, 7);
                rd = $urandom_range(0, 7);
                rw = ($urandom_range(0, 3) != 0);
                mr = rw && ($urandom_range(0, 2) == 0);
            end
            step(v, rs, rt, rd, rw, mr);
        end

        // Reset mid-run, asserted between edges
        step(1, 1, 1, 2, 1, 1);
        step(1, 2, 2, 3, 1, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("midrst_a", int'(fwd_a_sel_o), 0);
        check("midrst_b", int'(fwd_b_sel_o), 0);
        check("midrst_stall", int'(stall_o), 0);
        check("midrst_cnt", int'(stall_cnt_o), 0);
        model_reset();
        last_stall = 0;
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        step(1, 1, 1, 7, 1, 0);
        step(1, 7, 1, 8, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
